// File: rtl/pc_gen.sv
// Fetch-PC stage: holds the fetch address, predicts the next one through a
// direct-mapped BTB with 2-bit counters, and buffers redirects that arrive under stall.
package pc_gen_pkg;
  typedef struct packed {
    logic stall;
    logic flush;
  } pipe_control_t;
endpackage

module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  pipe_control_t pc_pipe,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_target,
  input  logic          upd_valid,
  input  logic [31:0]   upd_pc,
  input  logic [31:0]   upd_target,
  input  logic          upd_taken,
  output logic [31:0]   pc,
  output logic [31:0]   pc_ff,
  output logic          pred_taken_ff,
  output logic [31:0]   pred_target_ff
);

  localparam int unsigned IW = $clog2(BTB_ENTRIES);
  localparam int unsigned TW = 30 - IW;

  logic          btb_valid [BTB_ENTRIES];
  logic [TW-1:0] btb_tag   [BTB_ENTRIES];
  logic [29:0]   btb_tgt   [BTB_ENTRIES];
  logic [1:0]    btb_ctr   [BTB_ENTRIES];

  logic          pending_valid;
  logic [31:0]   pending_target;

  logic [IW-1:0] idx_c;
  logic [TW-1:0] tag_c;
  logic          hit_c;
  logic          pred_taken_c;
  logic [31:0]   npc_c;

  logic [IW-1:0] upd_idx_c;
  logic [TW-1:0] upd_tag_c;
  logic          upd_hit_c;
  logic          unused_c;

  // Prediction for the address currently being fetched
  always_comb begin
    idx_c        = pc[IW+1:2];
    tag_c        = pc[31:IW+2];
    hit_c        = btb_valid[idx_c] && (btb_tag[idx_c] == tag_c);
    pred_taken_c = hit_c && btb_ctr[idx_c][1];
    npc_c        = pred_taken_c ? {btb_tgt[idx_c], 2'b00} : pc + 32'd4;
  end

  always_comb begin
    upd_idx_c = upd_pc[IW+1:2];
    upd_tag_c = upd_pc[31:IW+2];
    upd_hit_c = btb_valid[upd_idx_c] && (btb_tag[upd_idx_c] == upd_tag_c);
  end

  // Low address bits never reach the BTB; flush does not affect fetch
  assign unused_c = ^{pc_pipe.flush, upd_pc[1:0], upd_target[1:0]};

  // Valid bits are the only BTB state that needs reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
    end else if (upd_valid && (upd_hit_c || upd_taken)) begin
      btb_valid[upd_idx_c] <= 1'b1;
    end
  end

  // Training: saturating counter on a hit, allocate on a taken miss
  always_ff @(posedge clk) begin
    if (!rst && upd_valid) begin
      if (upd_hit_c) begin
        if (upd_taken) begin
          btb_ctr[upd_idx_c] <= (btb_ctr[upd_idx_c] == 2'd3) ? 2'd3 : btb_ctr[upd_idx_c] + 2'd1;
          btb_tgt[upd_idx_c] <= upd_target[31:2];
        end else begin
          btb_ctr[upd_idx_c] <= (btb_ctr[upd_idx_c] == 2'd0) ? 2'd0 : btb_ctr[upd_idx_c] - 2'd1;
        end
      end else if (upd_taken) begin
        btb_tag[upd_idx_c] <= upd_tag_c;
        btb_tgt[upd_idx_c] <= upd_target[31:2];
        btb_ctr[upd_idx_c] <= 2'b10;
      end
    end
  end

  // Fetch PC: frozen under stall, redirects parked until the stall lifts
  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      pc_ff          <= RESET_PC;
      pred_taken_ff  <= 1'b0;
      pred_target_ff <= RESET_PC + 32'd4;
      pending_valid  <= 1'b0;
      pending_target <= '0;
    end else if (pc_pipe.stall) begin
      if (redirect_valid) begin
        pending_valid  <= 1'b1;
        pending_target <= redirect_target;
      end
    end else begin
      if (redirect_valid)     pc <= redirect_target;
      else if (pending_valid) pc <= pending_target;
      else                    pc <= npc_c;
      pending_valid  <= 1'b0;
      pc_ff          <= pc;
      pred_taken_ff  <= pred_taken_c;
      pred_target_ff <= npc_c;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: each scenario queues the expected fetch state per
// cycle and compares it against the DUT one cycle later.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam logic [31:0] B = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst;
  pipe_control_t pc_pipe;
  logic          redirect_valid;
  logic [31:0]   redirect_target;
  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic [31:0]   upd_target;
  logic          upd_taken;
  logic [31:0]   pc;
  logic [31:0]   pc_ff;
  logic          pred_taken_ff;
  logic [31:0]   pred_target_ff;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        r;
    logic        st;
    logic        rv;
    logic [31:0] rt;
    logic        uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        utk;
    logic [31:0] epc;
    logic [31:0] eff;
    logic        ept;
  } step_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ff;
    logic        pt;
  } exp_t;

  exp_t sb[$];

  pc_gen #(.RESET_PC(B), .BTB_ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .pc_pipe(pc_pipe),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .pc(pc), .pc_ff(pc_ff), .pred_taken_ff(pred_taken_ff), .pred_target_ff(pred_target_ff)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(logic r, logic st, logic rv, logic [31:0] rt,
                               logic uv, logic [31:0] upc, logic [31:0] utgt, logic utk,
                               logic [31:0] epc, logic [31:0] eff, logic ept);
    step_t s;
    s.r = r; s.st = st; s.rv = rv; s.rt = rt;
    s.uv = uv; s.upc = upc; s.utgt = utgt; s.utk = utk;
    s.epc = epc; s.eff = eff; s.ept = ept;
    return s;
  endfunction

  // Plain step: optional stall / redirect, no training
  function automatic step_t ps(logic st, logic rv, logic [31:0] rt,
                               logic [31:0] epc, logic [31:0] eff, logic ept);
    return mk(1'b0, st, rv, rt, 1'b0, '0, '0, 1'b0, epc, eff, ept);
  endfunction

  // Training step with no stall and no redirect
  function automatic step_t us(logic [31:0] upc, logic [31:0] utgt, logic utk,
                               logic [31:0] epc, logic [31:0] eff, logic ept);
    return mk(1'b0, 1'b0, 1'b0, '0, 1'b1, upc, utgt, utk, epc, eff, ept);
  endfunction

  task automatic drive(input step_t s);
    rst             = s.r;
    pc_pipe.stall   = s.st;
    pc_pipe.flush   = 1'b0;
    redirect_valid  = s.rv;
    redirect_target = s.rt;
    upd_valid       = s.uv;
    upd_pc          = s.upc;
    upd_target      = s.utgt;
    upd_taken       = s.utk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t v[$];
    exp_t  e;
    drive(mk(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0));
    tick();
    tick();
    total++;
    if (pc !== B || pc_ff !== B || pred_taken_ff !== 1'b0 || pred_target_ff !== B + 32'd4) begin
      bad++;
      $display("FAIL reset_state: pc=%h pc_ff=%h pt=%b ptgt=%h, required %h %h 0 %h",
               pc, pc_ff, pred_taken_ff, pred_target_ff, B, B, B + 32'd4);
    end
    v.push_back(ps(0, 0, '0, B + 32'h04, B + 32'h00, 0));
    v.push_back(ps(0, 0, '0, B + 32'h08, B + 32'h04, 0));
    v.push_back(ps(0, 0, '0, B + 32'h0C, B + 32'h08, 0));
    v.push_back(ps(0, 0, '0, B + 32'h10, B + 32'h0C, 0));
    foreach (v[i]) begin
      drive(v[i]);
      sb.push_back('{pc: v[i].epc, ff: v[i].eff, pt: v[i].ept});
      tick();
      e = sb.pop_front();
      total++;
      if (pc !== e.pc || pc_ff !== e.ff || pred_taken_ff !== e.pt) begin
        bad++;
        $display("FAIL seq_fetch[%0d]: pc=%h pc_ff=%h pt=%b, required %h %h %b",
                 i, pc, pc_ff, pred_taken_ff, e.pc, e.ff, e.pt);
      end
    end
  endtask

  task automatic test_stall();
    step_t v[$];
    exp_t  e;
    for (int k = 0; k < 3; k++) v.push_back(ps(1, 0, '0, B + 32'h10, B + 32'h0C, 0));
    v.push_back(ps(0, 0, '0, B + 32'h14, B + 32'h10, 0));
    foreach (v[i]) begin
      drive(v[i]);
      sb.push_back('{pc: v[i].epc, ff: v[i].eff, pt: v[i].ept});
      tick();
      e = sb.pop_front();
      total++;
      if (pc !== e.pc || pc_ff !== e.ff || pred_taken_ff !== e.pt) begin
        bad++;
        $display("FAIL stall_hold[%0d]: pc=%h pc_ff=%h pt=%b, required %h %h %b",
                 i, pc, pc_ff, pred_taken_ff, e.pc, e.ff, e.pt);
      end
    end
  endtask

  task automatic test_redirect();
    step_t v[$];
    exp_t  e;
    v.push_back(ps(0, 0, '0, B + 32'h18, B + 32'h14, 0));
    v.push_back(ps(0, 0, '0, B + 32'h1C, B + 32'h18, 0));
    v.push_back(ps(0, 0, '0, B + 32'h20, B + 32'h1C, 0));
    v.push_back(ps(0, 1, B + 32'h100, B + 32'h100, B + 32'h20, 0));
    foreach (v[i]) begin
      drive(v[i]);
      sb.push_back('{pc: v[i].epc, ff: v[i].eff, pt: v[i].ept});
      tick();
      e = sb.pop_front();
      total++;
      if (pc !== e.pc || pc_ff !== e.ff || pred_taken_ff !== e.pt) begin
        bad++;
        $display("FAIL redirect[%0d]: pc=%h pc_ff=%h pt=%b, required %h %h %b",
                 i, pc, pc_ff, pred_taken_ff, e.pc, e.ff, e.pt);
      end
    end
  endtask

  task automatic test_pending();
    step_t v[$];
    exp_t  e;
    v.push_back(ps(1, 1, B + 32'h200, B + 32'h100, B + 32'h20, 0));
    v.push_back(ps(1, 1, B + 32'h300, B + 32'h100, B + 32'h20, 0));
    v.push_back(ps(1, 0, '0,          B + 32'h100, B + 32'h20, 0));
    v.push_back(ps(0, 0, '0,          B + 32'h300, B + 32'h100, 0));
    v.push_back(ps(0, 0, '0,          B + 32'h304, B + 32'h300, 0));
    v.push_back(ps(1, 1, B + 32'h500, B + 32'h304, B + 32'h300, 0));
    v.push_back(ps(0, 1, B + 32'h400, B + 32'h400, B + 32'h304, 0));
    v.push_back(ps(0, 0, '0,          B + 32'h404, B + 32'h400, 0));
    foreach (v[i]) begin
      drive(v[i]);
      sb.push_back('{pc: v[i].epc, ff: v[i].eff, pt: v[i].ept});
      tick();
      e = sb.pop_front();
      total++;
      if (pc !== e.pc || pc_ff !== e.ff || pred_taken_ff !== e.pt) begin
        bad++;
        $display("FAIL pending[%0d]: pc=%h pc_ff=%h pt=%b, required %h %h %b",
                 i, pc, pc_ff, pred_taken_ff, e.pc, e.ff, e.pt);
      end
    end
  endtask

  task automatic test_btb();
    step_t v[$];
    exp_t  e;
    v.push_back(us(B + 32'h40, B + 32'h80, 1, B + 32'h408, B + 32'h404, 0));
    v.push_back(ps(0, 1, B + 32'h40, B + 32'h40, B + 32'h408, 0));
    v.push_back(ps(0, 0, '0, B + 32'h80, B + 32'h40, 1));
    v.push_back(us(B + 32'h40, '0, 0, B + 32'h84, B + 32'h80, 0));
    v.push_back(us(B + 32'h40, '0, 0, B + 32'h88, B + 32'h84, 0));
    v.push_back(ps(0, 1, B + 32'h40, B + 32'h40, B + 32'h88, 0));
    v.push_back(ps(0, 0, '0, B + 32'h44, B + 32'h40, 0));
    v.push_back(ps(0, 1, B + 32'h50, B + 32'h50, B + 32'h44, 0));
    v.push_back(us(B + 32'h50, B + 32'h90, 1, B + 32'h54, B + 32'h50, 0));
    v.push_back(ps(0, 1, B + 32'h50, B + 32'h50, B + 32'h54, 0));
    v.push_back(ps(0, 0, '0, B + 32'h90, B + 32'h50, 1));
    foreach (v[i]) begin
      drive(v[i]);
      sb.push_back('{pc: v[i].epc, ff: v[i].eff, pt: v[i].ept});
      tick();
      e = sb.pop_front();
      total++;
      if (pc !== e.pc || pc_ff !== e.ff || pred_taken_ff !== e.pt) begin
        bad++;
        $display("FAIL btb_predict[%0d]: pc=%h pc_ff=%h pt=%b, required %h %h %b",
                 i, pc, pc_ff, pred_taken_ff, e.pc, e.ff, e.pt);
      end
      if (i == 2 || i == 6) begin
        total++;
        if (pred_target_ff !== e.pc) begin
          bad++;
          $display("FAIL btb_target[%0d]: pred_target_ff=%h, required %h", i, pred_target_ff, e.pc);
        end
      end
    end
  endtask

  task automatic test_alias();
    step_t v[$];
    exp_t  e;
    v.push_back(us(B + 32'h40, B + 32'h60, 1, B + 32'h94, B + 32'h90, 0));
    v.push_back(us(B + 32'h40, B + 32'h60, 1, B + 32'h98, B + 32'h94, 0));
    v.push_back(ps(0, 1, B + 32'h40, B + 32'h40, B + 32'h98, 0));
    v.push_back(ps(0, 0, '0, B + 32'h60, B + 32'h40, 1));
    v.push_back(us(B + 32'h80, B + 32'hC0, 1, B + 32'h64, B + 32'h60, 0));
    v.push_back(ps(0, 1, B + 32'h40, B + 32'h40, B + 32'h64, 0));
    v.push_back(ps(0, 0, '0, B + 32'h44, B + 32'h40, 0));
    v.push_back(ps(0, 1, B + 32'h80, B + 32'h80, B + 32'h44, 0));
    v.push_back(ps(0, 0, '0, B + 32'hC0, B + 32'h80, 1));
    foreach (v[i]) begin
      drive(v[i]);
      sb.push_back('{pc: v[i].epc, ff: v[i].eff, pt: v[i].ept});
      tick();
      e = sb.pop_front();
      total++;
      if (pc !== e.pc || pc_ff !== e.ff || pred_taken_ff !== e.pt) begin
        bad++;
        $display("FAIL alias[%0d]: pc=%h pc_ff=%h pt=%b, required %h %h %b",
                 i, pc, pc_ff, pred_taken_ff, e.pc, e.ff, e.pt);
      end
    end
  endtask

  task automatic test_reset_clears();
    step_t v[$];
    exp_t  e;
    v.push_back(ps(1, 1, B + 32'h700, B + 32'hC0, B + 32'h80, 1));
    v.push_back(mk(1, 1, 0, '0, 0, '0, '0, 0, B, B, 0));
    v.push_back(ps(0, 0, '0, B + 32'h04, B, 0));
    v.push_back(ps(0, 1, B + 32'h80, B + 32'h80, B + 32'h04, 0));
    v.push_back(ps(0, 0, '0, B + 32'h84, B + 32'h80, 0));
    v.push_back(ps(0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, B + 32'h84, 0));
    v.push_back(ps(0, 0, '0, 32'h0000_0000, 32'hFFFF_FFFC, 0));
    v.push_back(ps(0, 0, '0, 32'h0000_0004, 32'h0000_0000, 0));
    foreach (v[i]) begin
      drive(v[i]);
      sb.push_back('{pc: v[i].epc, ff: v[i].eff, pt: v[i].ept});
      tick();
      e = sb.pop_front();
      total++;
      if (pc !== e.pc || pc_ff !== e.ff || pred_taken_ff !== e.pt) begin
        bad++;
        $display("FAIL reset_clear[%0d]: pc=%h pc_ff=%h pt=%b, required %h %h %b",
                 i, pc, pc_ff, pred_taken_ff, e.pc, e.ff, e.pt);
      end
      if (i == 1 || i == 6) begin
        total++;
        if (pred_target_ff !== e.pc + 32'd4 && i == 1 || pred_target_ff !== e.pc && i == 6) begin
          bad++;
          $display("FAIL reset_target[%0d]: pred_target_ff=%h, pc=%h", i, pred_target_ff, e.pc);
        end
      end
    end
  endtask

  initial begin
    drive(mk(1, 0, 0, '0, 0, '0, '0, 0, '0, '0, 0));
    test_reset();
    test_stall();
    test_redirect();
    test_pending();
    test_btb();
    test_alias();
    test_reset_clears();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
